// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared register map, FSM states and vector layout for the interrupt controller
package irq_pkg;

  typedef enum logic [1:0] {
    IRQ_STATUS = 2'd0,
    IRQ_MASK   = 2'd1,
    IRQ_VECTOR = 2'd2,
    IRQ_CLEAR  = 2'd3
  } irq_reg_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } irq_state_e;

  localparam int IRQ_VALID_BIT = 15;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - fixed-priority encoder, lowest set index wins
module irq_prio_enc #(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] req,
  output logic [3:0]      idx,
  output logic            valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Scan downward so the last hit, the lowest index, is the one kept.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_irq_ctrl.sv
// rtl/io_irq_ctrl.sv - bus slave merging edge-latched requests into a single active-low nIRQ
module io_irq_ctrl
  import irq_pkg::*;
#(
  parameter int NSRC    = 4,
  parameter int HOLDOFF = 2
) (
  input  logic            Clock,
  input  logic            nReset,
  input  logic            nSel,
  input  logic            RnW,
  input  logic            nOE,
  input  logic [1:0]      Addr,
  inout  wire  [15:0]     Data,
  input  logic [NSRC-1:0] Req,
  output logic            nIRQ
);

  localparam int CW = $clog2(HOLDOFF + 1);

  logic [NSRC-1:0] pending, mask, req_q, clr, pend_en;
  logic            rd_q, wr_q, rd_act, wr_act, rd_start, wr_start, ack;
  logic [3:0]      win_idx;
  logic            win_valid;
  logic [15:0]     vec_live, vec_q, rdata;
  logic [CW-1:0]   hold_cnt;
  irq_state_e      state, state_n;
  irq_reg_e        reg_sel;
  logic            unused_data;

  assign reg_sel     = irq_reg_e'(Addr);
  assign rd_act      = !nSel && RnW && !nOE;
  assign wr_act      = !nSel && !RnW;
  assign rd_start    = rd_act && !rd_q;
  assign wr_start    = wr_act && !wr_q;
  assign pend_en     = pending & mask;
  assign ack         = rd_start && (reg_sel == IRQ_VECTOR) && win_valid;
  assign unused_data = ^Data;

  irq_prio_enc #(.NSRC(NSRC)) u_enc (
    .req   (pend_en),
    .idx   (win_idx),
    .valid (win_valid)
  );

  always_comb begin
    vec_live                = '0;
    vec_live[IRQ_VALID_BIT] = win_valid;
    vec_live[3:0]           = win_valid ? win_idx : 4'd0;
  end

  always_comb begin
    clr = '0;
    if (wr_start && reg_sel == IRQ_CLEAR) clr = Data[NSRC-1:0];
    for (int i = 0; i < NSRC; i++) begin
      if (ack && win_idx == 4'(i)) clr[i] = 1'b1;
    end
  end

  // After the first read edge VECTOR shows the snapshot, not the post-ack state.
  always_comb begin
    case (reg_sel)
      IRQ_STATUS: rdata = 16'(pending);
      IRQ_MASK:   rdata = 16'(mask);
      IRQ_VECTOR: rdata = rd_q ? vec_q : vec_live;
      default:    rdata = 16'h0000;
    endcase
  end

  assign Data = rd_act ? rdata : 16'hzzzz;

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      pending <= '0;
      mask    <= '0;
      // History tracks the lines through reset so a level held across it is not an edge.
      req_q   <= Req;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      vec_q   <= '0;
    end else begin
      pending <= (pending & ~clr) | (Req & ~req_q);
      req_q   <= Req;
      rd_q    <= rd_act;
      wr_q    <= wr_act;
      if (wr_start && reg_sel == IRQ_MASK) mask <= Data[NSRC-1:0];
      if (rd_start) vec_q <= vec_live;
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (|pend_en) state_n = ASSERT;
      ASSERT: begin
        if (ack)            state_n = HOLD;
        else if (!(|pend_en)) state_n = IDLE;
      end
      HOLD:    if (hold_cnt == CW'(HOLDOFF - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign nIRQ = (state != ASSERT);

endmodule

// File: tb/tb_io_irq_ctrl.sv
// tb/tb_io_irq_ctrl.sv - directed and randomized checks of io_irq_ctrl against a behavioural model
module tb_io_irq_ctrl;

  localparam int NSRC    = 4;
  localparam int HOLDOFF = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sel_n = 1'b1;
  logic            rnw = 1'b1;
  logic            oe_n = 1'b1;
  logic [1:0]      addr = 2'd0;
  logic [NSRC-1:0] req = '0;
  logic            drv_en = 1'b0;
  logic [15:0]     drv_val = 16'h0;
  wire  [15:0]     data_bus;
  wire             nirq;

  int n_assert = 0;
  int n_fail   = 0;

  assign data_bus = drv_en ? drv_val : 16'hzzzz;

  always #5 clk = ~clk;

  io_irq_ctrl #(.NSRC(NSRC), .HOLDOFF(HOLDOFF)) dut (
    .Clock  (clk),
    .nReset (rst_n),
    .nSel   (sel_n),
    .RnW    (rnw),
    .nOE    (oe_n),
    .Addr   (addr),
    .Data   (data_bus),
    .Req    (req),
    .nIRQ   (nirq)
  );

  logic [NSRC-1:0] m_pend = '0, m_mask = '0, m_prev = '0;
  logic            m_rd_prev = 1'b0, m_wr_prev = 1'b0;

  function automatic logic [15:0] ref_vector(input logic [NSRC-1:0] p, input logic [NSRC-1:0] m);
    for (int i = 0; i < NSRC; i++) if (p[i] && m[i]) return 16'h8000 | 16'(i);
    return 16'h0000;
  endfunction

  function automatic logic [15:0] ref_read(input logic [1:0] a);
    case (a)
      2'd0:    return 16'(m_pend);
      2'd1:    return 16'(m_mask);
      2'd2:    return ref_vector(m_pend, m_mask);
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic            rd, wr;
    logic [NSRC-1:0] c;
    logic [15:0]     v;
    rd = !sel_n && rnw && !oe_n;
    wr = !sel_n && !rnw;
    c  = '0;
    if (!rst_n) begin
      m_pend    <= '0;
      m_mask    <= '0;
      m_prev    <= req;
      m_rd_prev <= 1'b0;
      m_wr_prev <= 1'b0;
    end else begin
      if (wr && !m_wr_prev && addr == 2'd1) m_mask <= drv_val[NSRC-1:0];
      if (wr && !m_wr_prev && addr == 2'd3) c = drv_val[NSRC-1:0];
      if (rd && !m_rd_prev && addr == 2'd2) begin
        v = ref_vector(m_pend, m_mask);
        if (v[15]) c[v[1:0]] = 1'b1;
      end
      m_pend    <= (m_pend & ~c) | (req & ~m_prev);
      m_prev    <= req;
      m_rd_prev <= rd;
      m_wr_prev <= wr;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; rnw = 1'b0; sel_n = 1'b0; drv_val = d; drv_en = 1'b1;
    @(negedge clk);
    sel_n = 1'b1; rnw = 1'b1; drv_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input string tag, output logic [15:0] d);
    @(negedge clk);
    addr = a; rnw = 1'b1; sel_n = 1'b0; oe_n = 1'b0;
    #1;
    d = data_bus;
    chk(tag, d, ref_read(a));
    @(negedge clk);
    sel_n = 1'b1; oe_n = 1'b1;
  endtask

  task automatic wait_irq(input logic level, input int max_cycles, input string tag);
    for (int i = 0; i < max_cycles; i++) begin
      if (nirq === level) break;
      @(negedge clk);
    end
    chk(tag, {15'b0, nirq}, {15'b0, level});
  endtask

  task automatic pulse(input logic [NSRC-1:0] bits);
    @(negedge clk);
    req = req | bits;
    @(negedge clk);
    req = req & ~bits;
  endtask

  initial begin
    logic [15:0] d;

    // Reset with all requests high
    rst_n = 1'b0; req = '1;
    repeat (2) @(negedge clk);
    chk("reset_nirq", {15'b0, nirq}, 16'h0001);
    bus_read(2'd0, "reset_status", d);
    chk("reset_status_const", d, 16'h0000);
    bus_read(2'd1, "reset_mask", d);
    chk("reset_mask_const", d, 16'h0000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus_read(2'd0, "post_reset_status", d);
    chk("post_reset_status_const", d, 16'h0000);
    req = '0;

    // Single source
    bus_write(2'd1, 16'h0002);
    pulse(4'b0010);
    wait_irq(1'b0, 3, "single_irq_low");
    bus_read(2'd2, "single_vector", d);
    chk("single_vector_const", d, 16'h8001);
    for (int i = 0; i < HOLDOFF; i++) begin
      chk("single_holdoff_high", {15'b0, nirq}, 16'h0001);
      @(negedge clk);
    end
    bus_read(2'd0, "single_status", d);
    chk("single_status_const", d, 16'h0000);

    // Priority
    bus_write(2'd1, 16'h000F);
    pulse(4'b1001);
    wait_irq(1'b0, 3, "prio_irq_low");
    bus_read(2'd2, "prio_vector0", d);
    chk("prio_vector0_const", d, 16'h8000);
    chk("prio_release_high", {15'b0, nirq}, 16'h0001);
    wait_irq(1'b0, HOLDOFF + 4, "prio_reassert");
    bus_read(2'd2, "prio_vector3", d);
    chk("prio_vector3_const", d, 16'h8003);
    bus_read(2'd2, "prio_vector_none", d);
    chk("prio_vector_none_const", d, 16'h0000);

    // Masking and clear
    bus_write(2'd1, 16'h0000);
    pulse(4'b0100);
    bus_read(2'd0, "mask_status", d);
    chk("mask_status_const", d, 16'h0004);
    repeat (3) begin
      chk("masked_irq_high", {15'b0, nirq}, 16'h0001);
      @(negedge clk);
    end
    bus_write(2'd1, 16'h0004);
    wait_irq(1'b0, 3, "unmask_irq_low");
    bus_write(2'd3, 16'h0004);
    wait_irq(1'b1, 3, "clear_irq_high");
    bus_read(2'd0, "clear_status", d);
    pulse(4'b0100);
    wait_irq(1'b0, 3, "idle_retrigger_low");
    bus_write(2'd3, 16'h0004);
    wait_irq(1'b1, 3, "idle_retrigger_clear");

    // Set beats clear
    bus_write(2'd1, 16'h0000);
    pulse(4'b0001);
    @(negedge clk);
    addr = 2'd3; rnw = 1'b0; sel_n = 1'b0; drv_val = 16'h0001; drv_en = 1'b1;
    req[0] = 1'b1;
    @(negedge clk);
    sel_n = 1'b1; rnw = 1'b1; drv_en = 1'b0; req[0] = 1'b0;
    bus_read(2'd0, "set_beats_clear", d);
    chk("set_beats_clear_const", d, 16'h0001);

    // Long read
    bus_write(2'd3, 16'h000F);
    bus_write(2'd1, 16'h0003);
    pulse(4'b0011);
    bus_read(2'd0, "long_pre_status", d);
    chk("long_pre_status_const", d, 16'h0003);
    @(negedge clk);
    addr = 2'd2; rnw = 1'b1; sel_n = 1'b0; oe_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("long_read_vector", data_bus, 16'h8000);
      @(negedge clk);
    end
    sel_n = 1'b1; oe_n = 1'b1;
    bus_read(2'd0, "long_post_status", d);
    chk("long_post_status_const", d, 16'h0002);

    // Reset during an access with nIRQ low
    wait_irq(1'b0, HOLDOFF + 6, "abort_irq_low");
    @(negedge clk);
    addr = 2'd2; rnw = 1'b1; sel_n = 1'b0; oe_n = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    sel_n = 1'b1; oe_n = 1'b1; rst_n = 1'b1;
    chk("abort_nirq", {15'b0, nirq}, 16'h0001);
    bus_read(2'd0, "abort_status", d);
    bus_read(2'd1, "abort_mask", d);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      req = NSRC'($urandom);
      case ($urandom_range(0, 4))
        0:       bus_write(2'd1, 16'($urandom));
        1:       bus_write(2'd3, 16'($urandom));
        2:       bus_read(2'd0, "rand_status", d);
        3:       bus_read(2'd2, "rand_vector", d);
        default: bus_read(2'd1, "rand_mask", d);
      endcase
    end
    req = '0;
    repeat (2) @(negedge clk);
    bus_read(2'd0, "final_status", d);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
